rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 155 +++++++++++++++
 tb/tb_rom_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: receives a length-prefixed, XOR-checksummed byte stream and writes it
// into a word-wide ROM, holding the CPU in reset until a frame is loaded correctly.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), 4*N payload bytes (MSB first per
// word), then one checksum byte equal to the XOR of all payload bytes.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       single-cycle request to begin a load (IDLE/DONE/ERR only)
//   byte_valid_i  byte offered on byte_data_i
//   byte_data_i   offered byte
//   byte_ready_o  byte accepted this cycle when byte_valid_i is also high
//   en_w_rom_o    one-cycle ROM write strobe per word
//   w_rom_addr_o  ROM word address (held between strobes)
//   w_rom_data_o  ROM word data (held between strobes)
//   rst_rom_o     CPU/ROM-fetch reset, released only after a good load
//   busy_o        frame in progress
//   done_o        last load succeeded
//   err_o         last load failed (length or checksum)

module rom_loader #(
   parameter int unsigned ROM_DEPTH = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        en_w_rom_o,
   output logic [15:0] w_rom_addr_o,
   output logic [31:0] w_rom_data_o,
   output logic        rst_rom_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      StIdle,
      StLenHi,
      StLenLo,
      StData,
      StChk,
      StDone,
      StErr
   } state_t;

   state_t      state;
   logic        busy;        // high exactly in LEN_HI, LEN_LO, DATA, CHK
   logic [7:0]  len_hi;
   logic [15:0] word_count;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] shift;       // first three bytes of the word being assembled
   logic [7:0]  chk;
   logic        accept;
   logic [15:0] len_word;

   // Ready is the registered busy flag, so acceptance needs no extra decode.
   assign byte_ready_o = busy;
   assign busy_o       = busy;
   assign accept       = byte_valid_i && busy;
   assign len_word     = {len_hi, byte_data_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= StIdle;
         busy         <= 1'b0;
         len_hi       <= 8'h00;
         word_count   <= 16'h0000;
         word_idx     <= 16'h0000;
         byte_idx     <= 2'd0;
         shift        <= 24'h000000;
         chk          <= 8'h00;
         en_w_rom_o   <= 1'b0;
         w_rom_addr_o <= 16'h0000;
         w_rom_data_o <= 32'h00000000;
         rst_rom_o    <= 1'b1;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         en_w_rom_o <= 1'b0;
         case (state)
            StIdle, StDone, StErr: begin
               if (start_i) begin
                  state     <= StLenHi;
                  busy      <= 1'b1;
                  done_o    <= 1'b0;
                  err_o     <= 1'b0;
                  rst_rom_o <= 1'b1;
                  word_idx  <= 16'h0000;
                  byte_idx  <= 2'd0;
                  chk       <= 8'h00;
               end
            end
            StLenHi: begin
               if (accept) begin
                  len_hi <= byte_data_i;
                  state  <= StLenLo;
               end
            end
            StLenLo: begin
               if (accept) begin
                  word_count <= len_word;
                  if (32'(len_word) > ROM_DEPTH) begin
                     state <= StErr;
                     busy  <= 1'b0;
                     err_o <= 1'b1;
                  end else if (len_word == 16'h0000) begin
                     state <= StChk;
                  end else begin
                     state <= StData;
                  end
               end
            end
            StData: begin
               if (accept) begin
                  shift    <= {shift[15:0], byte_data_i};
                  chk      <= chk ^ byte_data_i;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     en_w_rom_o   <= 1'b1;
                     w_rom_data_o <= {shift, byte_data_i};
                     w_rom_addr_o <= word_idx;
                     word_idx     <= word_idx + 16'd1;
                     if (word_idx == word_count - 16'd1) begin
                        state <= StChk;
                     end
                  end
               end
            end
            StChk: begin
               if (accept) begin
                  busy <= 1'b0;
                  if (byte_data_i == chk) begin
                     state     <= StDone;
                     done_o    <= 1'b1;
                     rst_rom_o <= 1'b0;
                  end else begin
                     state <= StErr;
                     err_o <= 1'b1;
                  end
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed self-checking bench for rom_loader.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.

module tb_rom_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        en_w_rom;
   logic [15:0] w_rom_addr;
   logic [31:0] w_rom_data;
   logic        rst_rom;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [15:0] wa_q[$];
   logic [31:0] wd_q[$];

   rom_loader #(.ROM_DEPTH(1024)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .byte_valid_i (byte_valid),
      .byte_data_i  (byte_data),
      .byte_ready_o (byte_ready),
      .en_w_rom_o   (en_w_rom),
      .w_rom_addr_o (w_rom_addr),
      .w_rom_data_o (w_rom_data),
      .rst_rom_o    (rst_rom),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write strobe seen.
   always @(negedge clk) begin
      if (en_w_rom) begin
         wa_q.push_back(w_rom_addr);
         wd_q.push_back(w_rom_data);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles and wait until it is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int wait_cnt;
      byte_valid = 1'b0;
      idle(gap);
      byte_valid = 1'b1;
      byte_data  = b;
      wait_cnt   = 0;
      while (!byte_ready && wait_cnt < 200) begin
         @(negedge clk);
         wait_cnt++;
      end
      checks++;
      if (!byte_ready) begin
         errors++;
         $display("FAIL send_byte_timeout: byte_ready=%0b required 1", byte_ready);
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      idle(1);
      checks++; if (byte_ready !== 1'b0) begin errors++;
         $display("FAIL reset_ready: got %0b required 0", byte_ready); end
      checks++; if (en_w_rom !== 1'b0) begin errors++;
         $display("FAIL reset_en: got %0b required 0", en_w_rom); end
      checks++; if (w_rom_addr !== 16'h0) begin errors++;
         $display("FAIL reset_addr: got %h required 0000", w_rom_addr); end
      checks++; if (w_rom_data !== 32'h0) begin errors++;
         $display("FAIL reset_data: got %h required 00000000", w_rom_data); end
      checks++; if ({busy, done, err} !== 3'b000) begin errors++;
         $display("FAIL reset_flags: busy/done/err got %b required 000", {busy, done, err}); end
      checks++; if (rst_rom !== 1'b1) begin errors++;
         $display("FAIL reset_rst_rom: got %0b required 1", rst_rom); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_two_words();
      logic [7:0] frame[11];
      frame = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};  // XOR of this payload is 0x44
      wa_q.delete(); wd_q.delete();
      pulse_start();
      checks++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin errors++;
         $display("FAIL n2_busy_after_start: busy=%0b ready=%0b required 1 1", busy, byte_ready); end
      for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
      idle(1);
      checks++; if (wa_q.size() !== 2) begin errors++;
         $display("FAIL n2_write_count: got %0d required 2", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 16'd0 || wd_q[0] !== 32'h11223344) begin errors++;
            $display("FAIL n2_word0: got %h/%h required 0000/11223344", wa_q[0], wd_q[0]); end
         checks++; if (wa_q[1] !== 16'd1 || wd_q[1] !== 32'hAABBCCDD) begin errors++;
            $display("FAIL n2_word1: got %h/%h required 0001/aabbccdd", wa_q[1], wd_q[1]); end
      end
      checks++; if ({done, err, rst_rom, busy, byte_ready} !== 5'b10000) begin errors++;
         $display("FAIL n2_status: done/err/rst_rom/busy/ready got %b required 10000",
                  {done, err, rst_rom, busy, byte_ready}); end
      checks++; if (w_rom_addr !== 16'd1 || w_rom_data !== 32'hAABBCCDD) begin errors++;
         $display("FAIL n2_bus_hold: got %h/%h required 0001/aabbccdd", w_rom_addr, w_rom_data); end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] frame[7];
      frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};  // correct would be 0x22
      wa_q.delete(); wd_q.delete();
      pulse_start();
      checks++; if (done !== 1'b0 || rst_rom !== 1'b1) begin errors++;
         $display("FAIL bad_start_clears: done=%0b rst_rom=%0b required 0 1", done, rst_rom); end
      for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
      idle(1);
      checks++; if (wa_q.size() !== 1) begin errors++;
         $display("FAIL bad_write_count: got %0d required 1", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 16'd0 || wd_q[0] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL bad_word0: got %h/%h required 0000/deadbeef", wa_q[0], wd_q[0]); end
      end
      checks++; if ({err, done, rst_rom, busy} !== 4'b1010) begin errors++;
         $display("FAIL bad_status: err/done/rst_rom/busy got %b required 1010",
                  {err, done, rst_rom, busy}); end
   endtask

   task automatic test_zero_length();
      wa_q.delete(); wd_q.delete();
      pulse_start();
      checks++; if (err !== 1'b0) begin errors++;
         $display("FAIL n0_err_cleared: got %0b required 0", err); end
      send_byte(8'h00, 0);
      // start in mid-frame must be ignored
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      idle(1);
      checks++; if (wa_q.size() !== 0) begin errors++;
         $display("FAIL n0_no_writes: got %0d writes required 0", wa_q.size()); end
      checks++; if ({done, err, rst_rom} !== 3'b100) begin errors++;
         $display("FAIL n0_status: done/err/rst_rom got %b required 100", {done, err, rst_rom}); end
   endtask

   task automatic test_length_limit();
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      checks++; if ({err, byte_ready, busy, rst_rom} !== 4'b1001) begin errors++;
         $display("FAIL len1025_status: err/ready/busy/rst_rom got %b required 1001",
                  {err, byte_ready, busy, rst_rom}); end
      byte_valid = 1'b1; byte_data = 8'h55;
      idle(3);
      byte_valid = 1'b0;
      checks++; if (wa_q.size() !== 0 || err !== 1'b1) begin errors++;
         $display("FAIL len1025_no_writes: writes=%0d err=%0b required 0 1", wa_q.size(), err); end
      // Exactly ROM_DEPTH words is accepted.
      pulse_start();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      checks++; if ({err, busy, byte_ready} !== 3'b011) begin errors++;
         $display("FAIL len1024_accepted: err/busy/ready got %b required 011",
                  {err, busy, byte_ready}); end
      do_reset();
   endtask

   task automatic test_gaps();
      logic [31:0] words[5];
      logic [7:0]  sum;
      words = '{32'h01234567, 32'h89ABCDEF, 32'hFFFF0000, 32'h0F1E2D3C, 32'hC0FFEE00};
      sum = 8'h00;
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(8'h00, $urandom_range(0, 3));
      send_byte(8'h05, $urandom_range(0, 3));
      for (int w = 0; w < 5; w++) begin
         for (int b = 3; b >= 0; b--) begin
            send_byte(words[w][b*8 +: 8], $urandom_range(0, 3));
            sum = sum ^ words[w][b*8 +: 8];
         end
      end
      send_byte(sum, $urandom_range(0, 3));
      idle(1);
      checks++; if (wa_q.size() !== 5) begin errors++;
         $display("FAIL gaps_write_count: got %0d required 5", wa_q.size()); end
      else begin
         for (int w = 0; w < 5; w++) begin
            checks++; if (wa_q[w] !== 16'(w) || wd_q[w] !== words[w]) begin errors++;
               $display("FAIL gaps_word%0d: got %h/%h required %h/%h",
                        w, wa_q[w], wd_q[w], 16'(w), words[w]); end
         end
      end
      checks++; if ({done, err, rst_rom} !== 3'b100) begin errors++;
         $display("FAIL gaps_status: done/err/rst_rom got %b required 100", {done, err, rst_rom}); end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] frame[8];
      logic [7:0] again[7];
      frame = '{8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      again = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(frame[i], 0);
      // Reset with a byte and a start offered in the same cycle.
      rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h70;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
      checks++; if ({byte_ready, en_w_rom, busy, done, err, rst_rom} !== 6'b000001) begin errors++;
         $display("FAIL midrst_flags: ready/en/busy/done/err/rst_rom got %b required 000001",
                  {byte_ready, en_w_rom, busy, done, err, rst_rom}); end
      checks++; if (w_rom_addr !== 16'h0 || w_rom_data !== 32'h0) begin errors++;
         $display("FAIL midrst_bus: got %h/%h required 0000/00000000", w_rom_addr, w_rom_data); end
      idle(2);
      checks++; if (wa_q.size() !== 1 || busy !== 1'b0) begin errors++;
         $display("FAIL midrst_aborted: writes=%0d busy=%0b required 1 0", wa_q.size(), busy); end
      wa_q.delete(); wd_q.delete();
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(again[i], 0);
      idle(1);
      checks++; if (wa_q.size() !== 1) begin errors++;
         $display("FAIL reload_write_count: got %0d required 1", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 16'd0 || wd_q[0] !== 32'h01020304) begin errors++;
            $display("FAIL reload_word0: got %h/%h required 0000/01020304", wa_q[0], wd_q[0]); end
      end
      checks++; if ({done, err, rst_rom} !== 3'b100) begin errors++;
         $display("FAIL reload_status: done/err/rst_rom got %b required 100", {done, err, rst_rom}); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_two_words();
      test_bad_checksum();
      test_zero_length();
      test_length_limit();
      test_gaps();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
